// File: rtl/tensor_core_scheduler.sv
// -----------------------------------------------------------------------------
// tensor_core_scheduler
//
// Purpose:
//   Shares one sequential 4x4 int8 matrix engine between NUM_REQ requesters.
//   A round-robin arbiter grants one requester at a time. The granted operands
//   are latched. The result is built ELEMS_PER_CYCLE elements per cycle and
//   is returned with the owner's ID over a valid/ready response channel.
//
//   Matrix packing: element (i,j) lives at bits [((3-i)*4+(3-j))*8 +: 8].
//   All arithmetic is unsigned 8-bit and wraps modulo 256.
//
// Parameters:
//   NUM_REQ          number of requesters (2..4)
//   ELEMS_PER_CYCLE  result elements computed per cycle (1, 2 or 4)
//
// Ports:
//   clock_in        in   1            sole clock, rising edge
//   reset_in        in   1            synchronous, active-high reset
//   req_valid       in   NUM_REQ      per-requester request valid
//   req_ready       out  NUM_REQ      per-requester accept (one-hot or zero)
//   req_input1      in   NUM_REQ*128  matrix A, requester r at [r*128 +: 128]
//   req_input2      in   NUM_REQ*128  matrix B, same packing
//   req_accumulate  in   NUM_REQ      0 = multiply, 1 = multiply-accumulate
//   resp_valid      out  1            result available
//   resp_ready      in   1            consumer accepts result
//   resp_output     out  128          result matrix C
//   resp_id         out  RW           requester that owns resp_output
//   busy            out  1            high in COMPUTE or RESP
//
// Optional feature (macro TENSOR_CORE_SCHEDULER_PERF_EN):
//   perf_grant_count   out  NUM_REQ*16  per-requester saturating grant counts
//   perf_stall_cycles  out  16          saturating count of cycles with a
//                                       valid request but no handshake
//   perf_clear         in   1           synchronous clear, wins over increment
// -----------------------------------------------------------------------------
module tensor_core_scheduler #(
    parameter  int NUM_REQ         = 2,
    parameter  int ELEMS_PER_CYCLE = 1,
    localparam int RW              = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clock_in,
    input  logic                   reset_in,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*128-1:0] req_input1,
    input  logic [NUM_REQ*128-1:0] req_input2,
    input  logic [NUM_REQ-1:0]     req_accumulate,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [127:0]           resp_output,
    output logic [RW-1:0]          resp_id,
    output logic                   busy
`ifdef TENSOR_CORE_SCHEDULER_PERF_EN
    ,
    output logic [NUM_REQ*16-1:0]  perf_grant_count,
    output logic [15:0]            perf_stall_cycles,
    input  logic                   perf_clear
`endif
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_RESP    = 2'd2
    } state_e;

    // The element counter advances by CNT_STEP and wraps to 0 after the last
    // group, so a 4-bit counter covers all legal ELEMS_PER_CYCLE values.
    localparam logic [3:0] CNT_STEP = 4'(ELEMS_PER_CYCLE);
    localparam logic [3:0] LAST_CNT = 4'(16 - ELEMS_PER_CYCLE);

    state_e          state_q, state_d;
    logic [RW-1:0]   rr_q, rr_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [RW-1:0]   id_q, id_d;
    logic [127:0]    res_q, res_d;
    logic [127:0]    a_q, a_d;
    logic [127:0]    b_q, b_d;
    logic            acc_q, acc_d;

    logic [NUM_REQ-1:0] grant_vec;
    logic               grant_found;
    logic [RW-1:0]      grant_id;
    logic               handshake;

    // -------------------------------------------------------------------------
    // One result element: C[i][j] = (acc ? A[i][j] : 0) + sum_k A[i][k]*B[k][j],
    // all truncated to 8 bits. For 2-bit row/col indices, (3-x) is simply ~x,
    // so the byte offset of (i,j) is {~i, ~j, 3'b000}.
    // -------------------------------------------------------------------------
    function automatic logic [7:0] mma_elem(
        input logic [127:0] a,
        input logic [127:0] b,
        input logic         acc,
        input logic [3:0]   e
    );
        logic [1:0] i;
        logic [1:0] j;
        logic [1:0] kb;
        logic [7:0] sum;
        i   = e[3:2];
        j   = e[1:0];
        sum = acc ? a[{~i, ~j, 3'b000} +: 8] : 8'h00;
        for (int k = 0; k < 4; k++) begin
            kb  = 2'(k);
            sum = sum + a[{~i, ~kb, 3'b000} +: 8] * b[{~kb, ~j, 3'b000} +: 8];
        end
        return sum;
    endfunction

    // -------------------------------------------------------------------------
    // Round-robin pick: first valid requester searching upward from rr+1.
    // Both loops have constant bounds, so every index below is static.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable assigned in a combinational block gets a default
        // first; a path that leaves one unassigned would infer a latch.
        grant_vec   = '0;
        grant_found = 1'b0;
        grant_id    = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (!grant_found && req_valid[r] &&
                    (r == (int'(rr_q) + off) % NUM_REQ)) begin
                    grant_found  = 1'b1;
                    grant_id     = RW'(r);
                    grant_vec[r] = 1'b1;
                end
            end
        end
    end

    // Ready is only offered in IDLE; it is held low while reset is applied so
    // no requester sees an accept that the state register will discard.
    assign req_ready   = (state_q == S_IDLE && !reset_in) ? grant_vec : '0;
    assign handshake   = (state_q == S_IDLE) && grant_found;

    assign resp_valid  = (state_q == S_RESP);
    assign busy        = (state_q != S_IDLE);
    assign resp_output = res_q;
    assign resp_id     = id_q;

    // -------------------------------------------------------------------------
    // Next-state and datapath update
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        res_d   = res_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;

        unique case (state_q)
            S_IDLE: begin
                if (handshake) begin
                    for (int r = 0; r < NUM_REQ; r++) begin
                        if (grant_id == RW'(r)) begin
                            a_d   = req_input1[r*128 +: 128];
                            b_d   = req_input2[r*128 +: 128];
                            acc_d = req_accumulate[r];
                        end
                    end
                    id_d    = grant_id;
                    rr_d    = grant_id;
                    cnt_d   = '0;
                    state_d = S_COMPUTE;
                end
            end

            S_COMPUTE: begin
                // Element e sits at byte (15 - e), which for 4 bits is ~e.
                for (int g = 0; g < ELEMS_PER_CYCLE; g++) begin
                    res_d[{~(cnt_q + 4'(g)), 3'b000} +: 8] =
                        mma_elem(a_q, b_q, acc_q, cnt_q + 4'(g));
                end
                cnt_d = cnt_q + CNT_STEP;
                if (cnt_q == LAST_CNT) begin
                    state_d = S_RESP;
                end
            end

            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Control and result registers: all return to their reset values.
    always_ff @(posedge clock_in) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (reset_in) begin
            state_q <= S_IDLE;
            rr_q    <= RW'(NUM_REQ - 1);
            cnt_q   <= '0;
            id_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            res_q   <= res_d;
        end
    end

    // NOTE: operand latches carry no reset; they are only read in COMPUTE,
    // which is reachable solely through a grant that loads them.
    always_ff @(posedge clock_in) begin
        a_q   <= a_d;
        b_q   <= b_d;
        acc_q <= acc_d;
    end

`ifdef TENSOR_CORE_SCHEDULER_PERF_EN
    // -------------------------------------------------------------------------
    // Performance counters (saturating, clear has priority over increment)
    // -------------------------------------------------------------------------
    logic [NUM_REQ-1:0][15:0] perf_grant_q;
    logic [15:0]              perf_stall_q;

    always_ff @(posedge clock_in) begin
        if (reset_in || perf_clear) begin
            perf_grant_q <= '0;
            perf_stall_q <= '0;
        end else begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (handshake && grant_id == RW'(r) &&
                    perf_grant_q[r] != 16'hFFFF) begin
                    perf_grant_q[r] <= perf_grant_q[r] + 16'd1;
                end
            end
            if ((|req_valid) && !handshake && perf_stall_q != 16'hFFFF) begin
                perf_stall_q <= perf_stall_q + 16'd1;
            end
        end
    end

    assign perf_grant_count  = perf_grant_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

endmodule
